dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//   Arbitrates two load/store lanes (lane 1 = older, lane 2 = younger) onto a
//   dual-ported data memory. Two stores in the same cycle, or a lane-1 store
//   followed by an overlapping lane-2 load, are serialised. In that case the
//   pipeline stalls for one cycle. The lane-2 access is then buffered and
//   issued in a DRAIN cycle (for a store) or a REPLAY cycle (for a load).
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   MemWrite1_i/MemWrite2_i        lane store requests (store wins over load)
//   MemRead1_i/MemRead2_i          lane load requests
//   A1_i/A2_i, WD1_i/WD2_i         lane byte address / store data
//   Funct3_1_i/Funct3_2_i          lane load/store type
//   WE1/WE2                        memory port write enables
//   A1/A2, WD1/WD2                 memory port address / write data (0 when idle)
//   AddressingControl1/2           memory port funct3 (0 when idle)
//   Stall                          freeze both lanes this cycle
//   ConflictCount                  number of stall events
//
// Configuration:
//   DMEM_ARB_PERF_EN  when defined, ConflictCount is a wrapping 32-bit counter
//                     of IDLE->DRAIN / IDLE->REPLAY transitions. Otherwise it
//                     is tied to 0.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int XLEN          = 32,
  parameter int ADDRESS_WIDTH = 17
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MemWrite1_i,
  input  logic            MemWrite2_i,
  input  logic            MemRead1_i,
  input  logic            MemRead2_i,
  input  logic [XLEN-1:0] A1_i,
  input  logic [XLEN-1:0] A2_i,
  input  logic [XLEN-1:0] WD1_i,
  input  logic [XLEN-1:0] WD2_i,
  input  logic [2:0]      Funct3_1_i,
  input  logic [2:0]      Funct3_2_i,
  output logic            WE1,
  output logic            WE2,
  output logic [XLEN-1:0] A1,
  output logic [XLEN-1:0] A2,
  output logic [XLEN-1:0] WD1,
  output logic [XLEN-1:0] WD2,
  output logic [2:0]      AddressingControl1,
  output logic [2:0]      AddressingControl2,
  output logic            Stall,
  output logic [31:0]     ConflictCount
);

  typedef enum logic [1:0] {IDLE, DRAIN, REPLAY} state_t;

  state_t state, state_nxt;

  // Byte count of an access; funct3[1:0] == 11 is treated as zero-size.
  function automatic logic [ADDRESS_WIDTH:0] access_size(input logic [2:0] f3);
    logic [ADDRESS_WIDTH:0] sz;
    sz = '0;
    case (f3[1:0])
      2'b00:   sz[2:0] = 3'd1;
      2'b01:   sz[2:0] = 3'd2;
      2'b10:   sz[2:0] = 3'd4;
      default: sz[2:0] = 3'd0;
    endcase
    return sz;
  endfunction

  // A store on a lane takes precedence over a simultaneous load.
  logic st1, st2, ld1, ld2;
  assign st1 = MemWrite1_i;
  assign st2 = MemWrite2_i;
  assign ld1 = MemRead1_i & ~MemWrite1_i;
  assign ld2 = MemRead2_i & ~MemWrite2_i;

  // The extra zero MSB keeps a+size from wrapping at the top of the address space.
  logic [ADDRESS_WIDTH:0] a1_ext, a2_ext;
  logic                   overlap;
  assign a1_ext  = {1'b0, A1_i[ADDRESS_WIDTH-1:0]};
  assign a2_ext  = {1'b0, A2_i[ADDRESS_WIDTH-1:0]};
  assign overlap = (a1_ext < (a2_ext + access_size(Funct3_2_i))) &&
                   (a2_ext < (a1_ext + access_size(Funct3_1_i)));

  logic ss_conflict, sl_conflict, capture;
  assign ss_conflict = st1 & st2;
  assign sl_conflict = st1 & ld2 & overlap;
  assign capture     = (state == IDLE) & (ss_conflict | sl_conflict) & ~rst;

  // Lane-2 access held over from the stall cycle to the DRAIN/REPLAY cycle.
  logic [XLEN-1:0] buf_addr_p1, buf_data_p1;
  logic [2:0]      buf_f3_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      buf_addr_p1 <= '0;
      buf_data_p1 <= '0;
      buf_f3_p1   <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        buf_addr_p1 <= A2_i;
        buf_data_p1 <= WD2_i;
        buf_f3_p1   <= Funct3_2_i;
      end
    end
  end

  always_comb begin
    state_nxt          = state;
    WE1                = 1'b0;
    WE2                = 1'b0;
    A1                 = '0;
    A2                 = '0;
    WD1                = '0;
    WD2                = '0;
    AddressingControl1 = '0;
    AddressingControl2 = '0;
    Stall              = 1'b0;

    if (rst) begin
      // All ports are quiet during reset, so a pending DRAIN store is dropped.
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (st1 | ld1) begin
            A1                 = A1_i;
            AddressingControl1 = Funct3_1_i;
          end
          if (st1) begin
            WE1 = 1'b1;
            WD1 = WD1_i;
          end

          if (ss_conflict) begin
            // Port 2 stays idle; the younger store goes out next cycle.
            Stall     = 1'b1;
            state_nxt = DRAIN;
          end else begin
            if (st2 | ld2) begin
              A2                 = A2_i;
              AddressingControl2 = Funct3_2_i;
            end
            if (st2) begin
              WE2 = 1'b1;
              WD2 = WD2_i;
            end
            if (sl_conflict) begin
              // The load is presented now but its data is stale; it is
              // re-issued in REPLAY after the store has landed.
              Stall     = 1'b1;
              state_nxt = REPLAY;
            end
          end
        end

        DRAIN: begin
          WE2                = 1'b1;
          A2                 = buf_addr_p1;
          WD2                = buf_data_p1;
          AddressingControl2 = buf_f3_p1;
          state_nxt          = IDLE;
        end

        REPLAY: begin
          A2                 = buf_addr_p1;
          AddressingControl2 = buf_f3_p1;
          state_nxt          = IDLE;
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] conflict_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if ((state == IDLE) && (state_nxt != IDLE)) begin
      conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

  assign ConflictCount = conflict_cnt;
`else
  assign ConflictCount = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Table-driven check of dmem_arbiter, with a byte-addressed memory model on the
// two memory ports. Each record holds one cycle of lane inputs plus the required
// port outputs for that cycle. It may also hold the required read data on
// either port. Records are queued when they are driven, then popped and
// compared at the following negedge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWrite1_i, MemWrite2_i, MemRead1_i, MemRead2_i;
  logic [31:0] A1_i, A2_i, WD1_i, WD2_i;
  logic [2:0]  Funct3_1_i, Funct3_2_i;
  logic        WE1, WE2, Stall;
  logic [31:0] A1, A2, WD1, WD2, ConflictCount;
  logic [2:0]  AddressingControl1, AddressingControl2;

  dmem_arbiter #(.XLEN(32), .ADDRESS_WIDTH(17)) dut (
    .clk(clk), .rst(rst),
    .MemWrite1_i(MemWrite1_i), .MemWrite2_i(MemWrite2_i),
    .MemRead1_i(MemRead1_i), .MemRead2_i(MemRead2_i),
    .A1_i(A1_i), .A2_i(A2_i), .WD1_i(WD1_i), .WD2_i(WD2_i),
    .Funct3_1_i(Funct3_1_i), .Funct3_2_i(Funct3_2_i),
    .WE1(WE1), .WE2(WE2), .A1(A1), .A2(A2), .WD1(WD1), .WD2(WD2),
    .AddressingControl1(AddressingControl1), .AddressingControl2(AddressingControl2),
    .Stall(Stall), .ConflictCount(ConflictCount)
  );

  always #5 clk = ~clk;

  // Byte memory model (low 12 address bits), little-endian.
  logic [7:0] mem [0:4095];

  function automatic int size_of(input logic [2:0] f);
    case (f[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (WE1)
      for (int i = 0; i < 4; i++)
        if (i < size_of(AddressingControl1)) mem[A1[11:0] + 12'(i)] <= WD1[8*i +: 8];
    if (WE2)
      for (int i = 0; i < 4; i++)
        if (i < size_of(AddressingControl2)) mem[A2[11:0] + 12'(i)] <= WD2[8*i +: 8];
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [2:0] f);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = mem[a[11:0] + 12'(i)];
    case (f)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'd0, w[7:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  typedef struct {
    logic        rst;
    logic        mw1, mr1; logic [31:0] a1, wd1; logic [2:0] f1;
    logic        mw2, mr2; logic [31:0] a2, wd2; logic [2:0] f2;
    logic        we1; logic [31:0] ea1, ewd1; logic [2:0] ec1;
    logic        we2; logic [31:0] ea2, ewd2; logic [2:0] ec2;
    logic        stall;
    logic        c1; logic [31:0] rd1;
    logic        c2; logic [31:0] rd2;
  } vec_t;

  function automatic vec_t mk(
    input logic r,
    input logic mw1, input logic mr1, input logic [31:0] a1, input logic [31:0] wd1, input logic [2:0] f1,
    input logic mw2, input logic mr2, input logic [31:0] a2, input logic [31:0] wd2, input logic [2:0] f2,
    input logic we1, input logic [31:0] ea1, input logic [31:0] ewd1, input logic [2:0] ec1,
    input logic we2, input logic [31:0] ea2, input logic [31:0] ewd2, input logic [2:0] ec2,
    input logic st, input logic c1, input logic [31:0] rd1, input logic c2, input logic [31:0] rd2);
    vec_t v;
    v.rst = r;
    v.mw1 = mw1; v.mr1 = mr1; v.a1 = a1; v.wd1 = wd1; v.f1 = f1;
    v.mw2 = mw2; v.mr2 = mr2; v.a2 = a2; v.wd2 = wd2; v.f2 = f2;
    v.we1 = we1; v.ea1 = ea1; v.ewd1 = ewd1; v.ec1 = ec1;
    v.we2 = we2; v.ea2 = ea2; v.ewd2 = ewd2; v.ec2 = ec2;
    v.stall = st; v.c1 = c1; v.rd1 = rd1; v.c2 = c2; v.rd2 = rd2;
    return v;
  endfunction

  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t sb[$];
  vec_t vt[20];

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    rst = v.rst;
    MemWrite1_i = v.mw1; MemRead1_i = v.mr1; A1_i = v.a1; WD1_i = v.wd1; Funct3_1_i = v.f1;
    MemWrite2_i = v.mw2; MemRead2_i = v.mr2; A2_i = v.a2; WD2_i = v.wd2; Funct3_2_i = v.f2;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    check({tag, " ports"},
          144'({WE1, WE2, Stall, AddressingControl1, AddressingControl2, A1, A2, WD1, WD2}),
          144'({e.we1, e.we2, e.stall, e.ec1, e.ec2, e.ea1, e.ea2, e.ewd1, e.ewd2}));
    if (e.c1) check({tag, " rd1"}, 144'(mem_rd(A1, AddressingControl1)), 144'(e.rd1));
    if (e.c2) check({tag, " rd2"}, 144'(mem_rd(A2, AddressingControl2)), 144'(e.rd2));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_cnt;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

    //            r  mw1 mr1 a1        wd1          f1 mw2 mr2 a2       wd2          f2 we1 ea1       ewd1         ec1 we2 ea2      ewd2         ec2 st c1 rd1           c2 rd2
    vt[0]  = mk(1, 1, 0, 'h100,    'hAAAAAAAA, 2, 1, 0, 'h200, 'hBBBBBBBB, 2, 0, 0,        0,          0, 0, 0,     0,          0, 0, 0, 0,           0, 0);
    vt[1]  = mk(0, 1, 0, 'h100,    'hAAAAAAAA, 2, 1, 0, 'h200, 'hBBBBBBBB, 2, 1, 'h100,    'hAAAAAAAA, 2, 0, 0,     0,          0, 1, 0, 0,           0, 0);
    vt[2]  = mk(0, 0, 1, 'h300,    0,          2, 0, 1, 'h304, 0,          2, 0, 0,        0,          0, 1, 'h200, 'hBBBBBBBB, 2, 0, 0, 0,           0, 0);
    vt[3]  = mk(0, 1, 0, 'h40,     'h11111111, 2, 1, 0, 'h40,  'h22,       0, 1, 'h40,     'h11111111, 2, 0, 0,     0,          0, 1, 0, 0,           0, 0);
    vt[4]  = mk(0, 0, 0, 0,        0,          0, 0, 0, 0,     0,          0, 0, 0,        0,          0, 1, 'h40,  'h22,       0, 0, 0, 0,           0, 0);
    vt[5]  = mk(0, 1, 0, 'h80,     'hDEADBEEF, 2, 0, 1, 'h83,  0,          4, 1, 'h80,     'hDEADBEEF, 2, 0, 'h83,  0,          4, 1, 0, 0,           0, 0);
    vt[6]  = mk(0, 0, 0, 0,        0,          0, 0, 0, 0,     0,          0, 0, 0,        0,          0, 0, 'h83,  0,          4, 0, 0, 0,           1, 'hDE);
    vt[7]  = mk(0, 1, 0, 'h10,     'h1234,     1, 0, 1, 'h12,  0,          2, 1, 'h10,     'h1234,     1, 0, 'h12,  0,          2, 0, 0, 0,           0, 0);
    vt[8]  = mk(0, 0, 1, 'h40,     0,          2, 1, 0, 'h44,  'h55,       2, 0, 'h40,     0,          2, 1, 'h44,  'h55,       2, 0, 1, 'h11111122,  0, 0);
    vt[9]  = mk(0, 0, 1, 'h100,    0,          2, 0, 1, 'h200, 0,          2, 0, 'h100,    0,          2, 0, 'h200, 0,          2, 0, 1, 'hAAAAAAAA,  1, 'hBBBBBBBB);
    vt[10] = mk(0, 0, 0, 0,        0,          0, 0, 1, 'h40,  0,          2, 0, 0,        0,          0, 0, 'h40,  0,          2, 0, 0, 0,           1, 'h11111122);
    vt[11] = mk(0, 1, 1, 'h300,    'h77,       2, 0, 1, 'h300, 0,          2, 1, 'h300,    'h77,       2, 0, 'h300, 0,          2, 1, 0, 0,           0, 0);
    vt[12] = mk(0, 0, 0, 0,        0,          0, 0, 0, 0,     0,          0, 0, 0,        0,          0, 0, 'h300, 0,          2, 0, 0, 0,           1, 'h77);
    vt[13] = mk(0, 1, 0, 'h500,    'h5,        2, 1, 1, 'h600, 'h6,        2, 1, 'h500,    'h5,        2, 0, 0,     0,          0, 1, 0, 0,           0, 0);
    vt[14] = mk(1, 0, 0, 0,        0,          0, 0, 0, 0,     0,          0, 0, 0,        0,          0, 0, 0,     0,          0, 0, 0, 0,           0, 0);
    vt[15] = mk(0, 0, 0, 0,        0,          0, 0, 1, 'h600, 0,          2, 0, 0,        0,          0, 0, 'h600, 0,          2, 0, 0, 0,           1, 0);
    vt[16] = mk(0, 1, 0, 'h900,    'h9,        2, 0, 1, 'h900, 0,          3, 1, 'h900,    'h9,        2, 0, 'h900, 0,          3, 0, 0, 0,           0, 0);
    vt[17] = mk(0, 1, 0, 'h20000,  'hAB,       2, 0, 1, 'h0,   0,          4, 1, 'h20000,  'hAB,       2, 0, 0,     0,          4, 1, 0, 0,           0, 0);
    vt[18] = mk(0, 0, 0, 0,        0,          0, 0, 0, 0,     0,          0, 0, 0,        0,          0, 0, 0,     0,          4, 0, 0, 0,           1, 'hAB);
    vt[19] = mk(0, 1, 0, 'h1FFFF,  'hCC,       2, 0, 1, 'h0,   0,          0, 1, 'h1FFFF,  'hCC,       2, 0, 0,     0,          0, 0, 0, 0,           0, 0);

    rst = 1'b1;
    MemWrite1_i = 0; MemWrite2_i = 0; MemRead1_i = 0; MemRead2_i = 0;
    A1_i = 0; A2_i = 0; WD1_i = 0; WD2_i = 0; Funct3_1_i = 0; Funct3_2_i = 0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) apply(vt[i], $sformatf("vec%0d", i));

    // Counter starts from zero after reset.
    apply(mk(1, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0, 0, 0,0, 0,0), "rst2");
    check("count_after_reset", 144'(ConflictCount), 144'(0));

    // Store-store held for six cycles: stall alternates with DRAIN and is never back-to-back.
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0)
        apply(mk(0, 1,0,'h700,'h1,2, 1,0,'h704,'h2,2, 1,'h700,'h1,2, 0,0,0,0, 1, 0,0, 0,0), $sformatf("hold%0d", k));
      else
        apply(mk(0, 1,0,'h700,'h1,2, 1,0,'h704,'h2,2, 0,0,0,0, 1,'h704,'h2,2, 0, 0,0, 0,0), $sformatf("hold%0d", k));
    end

`ifdef DMEM_ARB_PERF_EN
    exp_cnt = 32'd3;
`else
    exp_cnt = 32'd0;
`endif
    check("conflict_count", 144'(ConflictCount), 144'(exp_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
